// File: rtl/sm_divider15_8.sv
// rtl/sm_divider15_8.sv - sequential sign-magnitude 15/8 restoring divider (option macro: SMDIV_REMAINDER_EN)
module sm_divider15_8 #(
    parameter int DW_MAG = 14,
    parameter int DV_MAG = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW_MAG:0]     dividend,
    input  logic [DV_MAG:0]     divisor,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DV_MAG:0]     quotient,
    output logic                ovf,
    output logic                dz
`ifdef SMDIV_REMAINDER_EN
,   output logic [DV_MAG:0]     remainder
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0]        CNT_START = 4'(DW_MAG - 1);
    localparam logic [DV_MAG-1:0] MAG_MAX   = '1;

    logic [1:0]          state_q,    state_d;
    logic [3:0]          cnt_q,      cnt_d;
    logic [DW_MAG-1:0]   dvd_q,      dvd_d;
    logic [DV_MAG-1:0]   dvs_q,      dvs_d;
    logic [DV_MAG-1:0]   prem_q,     prem_d;
    logic [DW_MAG-1:0]   quo_q,      quo_d;
    logic                sign_q,     sign_d;
    logic [DV_MAG:0]     quotient_q, quotient_d;
    logic                ovf_q,      ovf_d;
    logic                dz_q,       dz_d;
`ifdef SMDIV_REMAINDER_EN
    logic                rsign_q,    rsign_d;
    logic [DV_MAG:0]     remainder_q, remainder_d;
`endif

    // -0 on either operand behaves as +0, so its sign bit never reaches the result
    logic in_sdvd, in_sdvs;
    assign in_sdvd = dividend[DW_MAG] & (|dividend[DW_MAG-1:0]);
    assign in_sdvs = divisor[DV_MAG]  & (|divisor[DV_MAG-1:0]);

    // One restoring step: shift in the next dividend bit, trial-subtract the divisor
    logic [DV_MAG:0]   trial_shift;
    logic [DV_MAG+1:0] trial_diff;
    logic              qbit;
    logic [DV_MAG-1:0] prem_new;
    logic [DW_MAG-1:0] quo_new;
    logic [DV_MAG-1:0] sat_mag;
    logic              sat_ovf;

    // Partial remainder stays below the divisor, so a non-negative difference
    // always has its top two bits clear; either one set means the trial failed.
    always_comb begin
        trial_shift = {prem_q, dvd_q[DW_MAG-1]};
        trial_diff  = {1'b0, trial_shift} - {2'b00, dvs_q};
        qbit        = ~(trial_diff[DV_MAG+1] | trial_diff[DV_MAG]);
        prem_new    = qbit ? trial_diff[DV_MAG-1:0] : trial_shift[DV_MAG-1:0];
        quo_new     = {quo_q[DW_MAG-2:0], qbit};
        sat_ovf     = |quo_new[DW_MAG-1:DV_MAG];
        sat_mag     = sat_ovf ? MAG_MAX : quo_new[DV_MAG-1:0];
    end

    // Next-state logic for the IDLE -> CALC -> DONE -> IDLE sequence
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        prem_d     = prem_q;
        quo_d      = quo_q;
        sign_d     = sign_q;
        quotient_d = quotient_q;
        ovf_d      = ovf_q;
        dz_d       = dz_q;
`ifdef SMDIV_REMAINDER_EN
        rsign_d     = rsign_q;
        remainder_d = remainder_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    dvd_d  = dividend[DW_MAG-1:0];
                    dvs_d  = divisor[DV_MAG-1:0];
                    sign_d = in_sdvd ^ in_sdvs;
                    prem_d = '0;
                    quo_d  = '0;
                    cnt_d  = CNT_START;
`ifdef SMDIV_REMAINDER_EN
                    rsign_d = in_sdvd;
`endif
                    if (divisor[DV_MAG-1:0] == '0) begin
                        // Divide by zero: saturate immediately, skipping the iterations
                        state_d    = ST_DONE;
                        quotient_d = {in_sdvd, MAG_MAX};
                        ovf_d      = 1'b0;
                        dz_d       = 1'b1;
`ifdef SMDIV_REMAINDER_EN
                        remainder_d = '0;
`endif
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                prem_d = prem_new;
                quo_d  = quo_new;
                dvd_d  = {dvd_q[DW_MAG-2:0], 1'b0};
                cnt_d  = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    state_d    = ST_DONE;
                    quotient_d = {sign_q & (|sat_mag), sat_mag};
                    ovf_d      = sat_ovf;
                    dz_d       = 1'b0;
`ifdef SMDIV_REMAINDER_EN
                    remainder_d = {rsign_q & (|prem_new), prem_new};
`endif
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers; reset drops any in-flight operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            prem_q     <= '0;
            quo_q      <= '0;
            sign_q     <= 1'b0;
            quotient_q <= '0;
            ovf_q      <= 1'b0;
            dz_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            prem_q     <= prem_d;
            quo_q      <= quo_d;
            sign_q     <= sign_d;
            quotient_q <= quotient_d;
            ovf_q      <= ovf_d;
            dz_q       <= dz_d;
        end
    end

`ifdef SMDIV_REMAINDER_EN
    // Remainder sign and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            rsign_q     <= 1'b0;
            remainder_q <= '0;
        end else begin
            rsign_q     <= rsign_d;
            remainder_q <= remainder_d;
        end
    end

    assign remainder = remainder_q;
`endif

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign quotient  = quotient_q;
    assign ovf       = ovf_q;
    assign dz        = dz_q;

endmodule
